uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset; all ports are listed below with clock and reset first.
- clk_i  input  1  block clock; all state updates on its rising edge.
- rst_ni  input  1  synchronous, active-low reset.
- rx_en  input  1  receive enable; when low the receiver stays in or returns to IDLE.
- CLKS_PER_BIT  input  16  clk_i cycles per bit; software keeps it at 4 or above.
- i_RX_Serial  input  1  asynchronous serial line; idles high; 8N1, LSB first.
- o_RX_Byte  output  8  last correctly framed byte.
- o_RX_Done  output  1  one-cycle pulse when a correctly framed byte is in o_RX_Byte.
- o_RX_Frame_Err  output  1  one-cycle pulse when the stop bit is sampled low.

Function
REQ-002 i_RX_Serial SHALL pass through a 2-flop synchronizer; both flops reset to 1; all line decisions use the second flop output ("rx_s").
REQ-003 The state machine SHALL have the states IDLE, RX_START_BIT, RX_DATA_BITS, RX_STOP_BIT and CLEANUP; any other encoding SHALL go to IDLE the next cycle.
REQ-004 IDLE behaviour:
- Clear the bit counter and bit index.
- If rx_en=1 and rx_s=0: latch CLKS_PER_BIT into an internal register ("cpb") and go to RX_START_BIT.
- Otherwise stay in IDLE.
REQ-005 CLKS_PER_BIT SHALL be sampled only at start detection; changes during a frame SHALL have no effect on that frame.
REQ-006 RX_START_BIT behaviour:
- Increment the counter each cycle from 0.
- When counter == (cpb-1)>>1 (mid start bit): if rx_s=0, clear the counter and go to RX_DATA_BITS.
- If rx_s=1 at that point, treat it as a glitch: go to IDLE with no output pulse.
REQ-007 RX_DATA_BITS behaviour:
- Increment the counter each cycle.
- When counter == cpb-1: write rx_s into shift register bit [index] (index 0 first), clear the counter and increment the index.
- After index 7 is sampled, go to RX_STOP_BIT.
REQ-008 Sample points SHALL therefore fall cpb cycles apart at mid-bit.
REQ-009 RX_STOP_BIT behaviour: count to cpb-1, then sample rx_s and go to CLEANUP.
- If rx_s=1: load the shift register into o_RX_Byte and assert o_RX_Done.
- If rx_s=0: assert o_RX_Frame_Err and leave o_RX_Byte unchanged.
REQ-010 o_RX_Done and o_RX_Frame_Err SHALL be registered and high for exactly the single CLEANUP cycle, and never high together.
REQ-011 CLEANUP SHALL last one cycle and then go to IDLE; a new start bit is accepted from the next IDLE cycle onward, which allows back-to-back frames with one stop bit.
REQ-012 o_RX_Byte SHALL hold its value until the next good frame completes.
REQ-013 If rx_en goes low in any non-IDLE state, the next state SHALL be IDLE with no pulse and o_RX_Byte unchanged; rx_en has no effect during CLEANUP.
REQ-014 Counter arithmetic SHALL be 16-bit unsigned; the counter never exceeds cpb-1 and the bit index wraps 7->0 only on the transition to RX_STOP_BIT.
REQ-015 Latency SHALL be 2 sync cycles + detection cycle + approx. 9.5*cpb cycles from the line falling edge to the o_RX_Done pulse.

Reset
REQ-016 While rst_ni=0 at a clock edge, the module SHALL enter the following reset state:
- State = IDLE; counter = 0; bit index = 0; shift register = 0x00.
- o_RX_Byte = 0x00, o_RX_Done = 0, o_RX_Frame_Err = 0.
- Synchronizer flops = 1.
REQ-017 Reset asserted mid-frame SHALL abort the frame with no pulse; reception restarts only on a new falling edge after release.

Verification
REQ-018 The bench SHALL cover at least the following directed scenarios:
- Good frame: CLKS_PER_BIT=16, rx_en=1, send 0xA5 8N1 -> o_RX_Byte=0xA5, o_RX_Done high exactly 1 cycle, o_RX_Frame_Err=0.
- Back-to-back: send 0x00 then 0xFF with no idle gap -> two o_RX_Done pulses, o_RX_Byte=0x00 then 0xFF.
- Glitch rejection: CLKS_PER_BIT=16, drive the line low for 4 cycles then high -> return to IDLE, no pulse, o_RX_Byte unchanged.
- Framing error: after a good 0x12, send 0x3C with stop bit=0 -> o_RX_Frame_Err 1-cycle pulse, o_RX_Done=0, o_RX_Byte stays 0x12.
- Reset mid-frame: assert rst_ni=0 during data bit 3 -> next cycle all outputs are at reset values; a following good frame 0x5A is received correctly.
- Enable and rate change: drop rx_en during data bits -> no pulse; change CLKS_PER_BIT mid-frame (16->8) -> the frame still decodes correctly at 16.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop line synchronizer, runtime bit period,
// registered one-cycle done / framing-error pulses.
module uart_rx (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_en,
    input  logic [15:0] CLKS_PER_BIT,
    input  logic        i_RX_Serial,
    output logic [7:0]  o_RX_Byte,
    output logic        o_RX_Done,
    output logic        o_RX_Frame_Err
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RX_START_BIT = 3'd1,
        RX_DATA_BITS = 3'd2,
        RX_STOP_BIT  = 3'd3,
        CLEANUP      = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic [15:0] r_cnt;
    logic [15:0] r_cpb;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic [15:0] w_half;
    logic [15:0] w_last;

    assign w_last = r_cpb - 16'd1;
    assign w_half = w_last >> 1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_RX_Serial;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state        <= IDLE;
            r_cnt          <= 16'd0;
            r_cpb          <= 16'd0;
            r_idx          <= 3'd0;
            r_shift        <= 8'h00;
            o_RX_Byte      <= 8'h00;
            o_RX_Done      <= 1'b0;
            o_RX_Frame_Err <= 1'b0;
        end else begin
            o_RX_Done      <= 1'b0;
            o_RX_Frame_Err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= 16'd0;
                    r_idx <= 3'd0;
                    if (rx_en && !r_rx_s) begin
                        r_cpb   <= CLKS_PER_BIT;
                        r_state <= RX_START_BIT;
                    end
                end
                RX_START_BIT: begin
                    if (!rx_en) begin
                        r_state <= IDLE;
                    end else if (r_cnt == w_half) begin
                        r_cnt   <= 16'd0;
                        // High at mid start bit means a glitch, not a frame
                        r_state <= r_rx_s ? IDLE : RX_DATA_BITS;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RX_DATA_BITS: begin
                    if (!rx_en) begin
                        r_state <= IDLE;
                    end else if (r_cnt == w_last) begin
                        r_cnt          <= 16'd0;
                        r_shift[r_idx] <= r_rx_s;
                        r_idx          <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= RX_STOP_BIT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RX_STOP_BIT: begin
                    if (!rx_en) begin
                        r_state <= IDLE;
                    end else if (r_cnt == w_last) begin
                        r_cnt   <= 16'd0;
                        r_state <= CLEANUP;
                        if (r_rx_s) begin
                            o_RX_Byte <= r_shift;
                            o_RX_Done <= 1'b1;
                        end else begin
                            o_RX_Frame_Err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                CLEANUP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed table, corner sequences,
// randomized frames against a frame-level scoreboard.
module tb_uart_rx;

    logic        clk;
    logic        rst_ni;
    logic        rx_en;
    logic [15:0] cpb_in;
    logic        line;
    logic [7:0]  rx_byte;
    logic        rx_done;
    logic        rx_ferr;

    uart_rx dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .rx_en          (rx_en),
        .CLKS_PER_BIT   (cpb_in),
        .i_RX_Serial    (line),
        .o_RX_Byte      (rx_byte),
        .o_RX_Done      (rx_done),
        .o_RX_Frame_Err (rx_ferr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int done_cyc = 0;
    int width_viol = 0;
    int both_high = 0;
    bit prev_done = 1'b0;
    bit prev_ferr = 1'b0;

    // Event = {is_frame_error, byte seen on o_RX_Byte during the pulse}
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            got_q.push_back({1'b0, rx_byte});
            done_cyc = cyc;
        end
        if (rx_ferr === 1'b1) got_q.push_back({1'b1, rx_byte});
        if (rx_done === 1'b1 && prev_done) width_viol++;
        if (rx_ferr === 1'b1 && prev_ferr) width_viol++;
        if (rx_done === 1'b1 && rx_ferr === 1'b1) both_high++;
        prev_done = (rx_done === 1'b1);
        prev_ferr = (rx_ferr === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drain(input string name);
        logic [8:0] e;
        logic [8:0] g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                check({name, "_missing_evt"}, 32'h1ff, {23'd0, e});
            end else begin
                g = got_q.pop_front();
                check({name, "_evt"}, {23'd0, g}, {23'd0, e});
            end
        end
        check({name, "_extra_evt"}, got_q.size(), 0);
        got_q.delete();
    endtask

    int c0 = 0;

    // Drives one frame; drop_bit/chg_bit < 0 disables enable drop / rate change
    task automatic send(input int cpb, input logic [7:0] d, input bit stop,
                        input int drop_bit, input int chg_bit);
        c0 = cyc;
        cpb_in = 16'(cpb);
        line = 1'b0;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == drop_bit) rx_en = 1'b0;
            if (i == chg_bit) cpb_in = 16'(cpb / 2);
            line = d[i];
            repeat (cpb) @(negedge clk);
        end
        line = stop;
        repeat (cpb) @(negedge clk);
        line = 1'b1;
        rx_en = 1'b1;
        if (drop_bit < 0) begin
            exp_q.push_back(stop ? {1'b0, d} : {1'b1, last_good});
            if (stop) last_good = d;
        end
    endtask

    typedef struct {
        int         cpb;
        logic [7:0] data;
        bit         stop;
        int         gap;
        bit         chk_lat;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16, 8'hA5, 1'b1, 2, 1'b1, 8'hA5};
        vecs[1] = '{16, 8'h00, 1'b1, 0, 1'b0, 8'h00};
        vecs[2] = '{16, 8'hFF, 1'b1, 2, 1'b0, 8'hFF};
        vecs[3] = '{16, 8'h12, 1'b1, 2, 1'b0, 8'h12};
        vecs[4] = '{16, 8'h3C, 1'b0, 3, 1'b0, 8'h12};
        vecs[5] = '{4,  8'hC3, 1'b1, 2, 1'b1, 8'hC3};
        vecs[6] = '{8,  8'h81, 1'b1, 0, 1'b0, 8'h81};
        vecs[7] = '{8,  8'h7E, 1'b1, 2, 1'b1, 8'h7E};

        rst_ni = 1'b0;
        rx_en  = 1'b0;
        line   = 1'b1;
        cpb_in = 16'd16;
        repeat (3) @(negedge clk);
        check("rst_byte", {24'd0, rx_byte}, 32'h00);
        check("rst_done", {31'd0, rx_done}, 32'h0);
        check("rst_ferr", {31'd0, rx_ferr}, 32'h0);
        rst_ni = 1'b1;
        rx_en  = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            send(vecs[v].cpb, vecs[v].data, vecs[v].stop, -1, -1);
            repeat (vecs[v].gap * vecs[v].cpb) @(negedge clk);
            if (vecs[v].gap > 0) begin
                drain($sformatf("vec%0d", v));
                check($sformatf("vec%0d_byte", v), {24'd0, rx_byte},
                      {24'd0, vecs[v].exp_byte});
                // 2 sync + detect + half start bit + 9 full bits
                if (vecs[v].chk_lat)
                    check($sformatf("vec%0d_latency", v), done_cyc - c0,
                          4 + ((vecs[v].cpb - 1) >> 1) + 9 * vecs[v].cpb);
            end
        end

        cpb_in = 16'd16;
        line = 1'b0;
        repeat (4) @(negedge clk);
        line = 1'b1;
        repeat (48) @(negedge clk);
        drain("glitch");
        check("glitch_byte", {24'd0, rx_byte}, {24'd0, last_good});

        send(16, 8'h99, 1'b1, 3, -1);
        repeat (32) @(negedge clk);
        drain("en_drop");
        check("en_drop_byte", {24'd0, rx_byte}, {24'd0, last_good});

        send(16, 8'h6D, 1'b1, -1, 2);
        repeat (32) @(negedge clk);
        drain("rate_chg");
        check("rate_chg_byte", {24'd0, rx_byte}, 32'h6D);

        cpb_in = 16'd16;
        line = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            line = ~i[0];
            repeat (16) @(negedge clk);
        end
        line = 1'b0;
        repeat (8) @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        check("midrst_byte", {24'd0, rx_byte}, 32'h00);
        check("midrst_done", {31'd0, rx_done}, 32'h0);
        check("midrst_ferr", {31'd0, rx_ferr}, 32'h0);
        rst_ni = 1'b1;
        line = 1'b1;
        last_good = 8'h00;
        repeat (48) @(negedge clk);
        drain("midrst");
        send(16, 8'h5A, 1'b1, -1, -1);
        repeat (32) @(negedge clk);
        drain("after_rst");
        check("after_rst_byte", {24'd0, rx_byte}, 32'h5A);

        for (int r = 0; r < 40; r++) begin
            int         cpb;
            logic [7:0] d;
            bit         stop;
            int         gap;
            cpb  = $urandom_range(4, 12);
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            gap  = stop ? $urandom_range(0, 2) : 2;
            send(cpb, d, stop, -1, -1);
            repeat (gap * cpb) @(negedge clk);
            if (gap > 0) begin
                drain($sformatf("rnd%0d", r));
                check($sformatf("rnd%0d_byte", r), {24'd0, rx_byte},
                      {24'd0, last_good});
            end
        end
        repeat (40) @(negedge clk);
        drain("rnd_final");
        check("rnd_final_byte", {24'd0, rx_byte}, {24'd0, last_good});

        check("pulse_width", width_viol, 0);
        check("done_and_err", both_high, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
